weight_ram_scheduler: RTL and testbench

//  Controller for the float16 kernel-weight RAM (100 x 16b; 4 slots of 5x5, 25 words each).

---
 rtl/weight_sched_pkg.sv | 24 ++
 rtl/weight_addr_gen.sv | 52 +++++
 rtl/weight_ram_scheduler.sv | 147 ++++++++++++++
 tb/tb_weight_ram_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_sched_pkg.sv
// rtl/weight_sched_pkg.sv - shared constants, FSM state type and job legality check for the weight RAM scheduler
package weight_sched_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int KS_MAX      = 5;
    localparam int SLOTS       = 4;
    localparam int SLOT_STRIDE = KS_MAX * KS_MAX;
    localparam int WADDR_W     = 5;
    localparam int RADDR_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD,
        ST_READ,
        ST_DONE
    } state_t;

    function automatic logic job_legal(input logic [2:0] ks, input logic [2:0] slice_num);
        return (ks != 3'd0) && (ks <= 3'(KS_MAX)) &&
               (slice_num != 3'd0) && (slice_num <= 3'(SLOTS));
    endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// rtl/weight_addr_gen.sv - slot/row/col read counters producing the row-major kernel word address
module weight_addr_gen
    import weight_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [2:0]         ks,
    input  logic [2:0]         slice_num,
    output logic [RADDR_W-1:0] ram_addr_read,
    output logic               last_in_slice,
    output logic               last_in_job
);

    logic [1:0] slot;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] ks_m1;
    logic [2:0] slice_m1;

    assign ks_m1         = ks - 3'd1;
    assign slice_m1      = slice_num - 3'd1;
    assign last_in_slice = (row == ks_m1) && (col == ks_m1);
    assign last_in_job   = last_in_slice && ({1'b0, slot} == slice_m1);

    // Slots sit at a fixed 25-word stride regardless of ks; rows at a fixed 5-word stride.
    assign ram_addr_read = RADDR_W'(slot) * RADDR_W'(SLOT_STRIDE)
                         + RADDR_W'(row) * RADDR_W'(KS_MAX)
                         + RADDR_W'(col);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot <= 2'd0;
            row  <= 3'd0;
            col  <= 3'd0;
        end else if (advance) begin
            if (col == ks_m1) begin
                col <= 3'd0;
                if (row == ks_m1) begin
                    row  <= 3'd0;
                    slot <= slot + 2'd1;
                end else begin
                    row <= row + 3'd1;
                end
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/weight_ram_scheduler.sv
// rtl/weight_ram_scheduler.sv - loads kernel slices into the weight RAM, then streams them to the MAC
// Optional stall counter output perf_stall_cnt when WEIGHT_SCHED_PERF_EN is defined.
module weight_ram_scheduler
    import weight_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             ks,
    input  logic [2:0]             slice_num,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [399:0]           load_data,
    output logic                   ram_ena_w,
    output logic [WADDR_W-1:0]     ram_addr_write,
    output logic [399:0]           ram_din,
    output logic                   ram_ena_r,
    output logic [RADDR_W-1:0]     ram_addr_read,
    input  logic [DATA_WIDTH-1:0]  ram_dout,
    output logic [DATA_WIDTH-1:0]  w_data,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic                   w_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef WEIGHT_SCHED_PERF_EN
    ,
    output logic [15:0]            perf_stall_cnt
`endif
);

    state_t     state;
    logic [2:0] ks_r;
    logic [2:0] slices_r;
    logic [1:0] wslot;
    logic       issued_all;
    logic       stall;
    logic       issue;
    logic       last_in_slice;
    logic       last_in_job;

    assign stall          = w_valid & ~w_ready;
    // A new read would overwrite ram_dout, so hold off while the MAC is stalling us.
    assign issue          = (state == ST_READ) & ~issued_all & ~stall;
    assign load_ready     = (state == ST_LOAD);
    assign ram_ena_w      = load_ready & load_valid;
    assign ram_addr_write = {3'b000, wslot};
    assign ram_din        = load_data;
    assign ram_ena_r      = issue;
    assign w_data         = ram_dout;
    assign busy           = (state != ST_IDLE);

    weight_addr_gen u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .clear         (state != ST_READ),
        .advance       (issue),
        .ks            (ks_r),
        .slice_num     (slices_r),
        .ram_addr_read (ram_addr_read),
        .last_in_slice (last_in_slice),
        .last_in_job   (last_in_job)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ks_r       <= 3'd0;
            slices_r   <= 3'd0;
            wslot      <= 2'd0;
            issued_all <= 1'b0;
            w_valid    <= 1'b0;
            w_last     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            w_valid <= issue | stall;
            if (issue) begin
                w_last <= last_in_slice;
            end else if (!stall) begin
                w_last <= 1'b0;
            end
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ks_r       <= ks;
                        slices_r   <= slice_num;
                        wslot      <= 2'd0;
                        issued_all <= 1'b0;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (job_legal(ks_r, slices_r)) begin
                        state <= ST_LOAD;
                    end else begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (ram_ena_w) begin
                        if ({1'b0, wslot} == slices_r - 3'd1) begin
                            wslot <= 2'd0;
                            state <= ST_READ;
                        end else begin
                            wslot <= wslot + 2'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue && last_in_job) begin
                        issued_all <= 1'b1;
                    end
                    // Once everything is issued the only word in flight is the final one.
                    if (issued_all && w_valid && w_ready) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef WEIGHT_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= 16'd0;
        end else if (state == ST_IDLE && start) begin
            perf_stall_cnt <= 16'd0;
        end else if (stall && perf_stall_cnt != 16'hFFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_ram_scheduler.sv
// tb/tb_weight_ram_scheduler.sv - directed self-checking bench for weight_ram_scheduler
module tb_weight_ram_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   ks;
    logic [2:0]   slice_num;
    logic         load_valid;
    logic         load_ready;
    logic [399:0] load_data;
    logic         ram_ena_w;
    logic [4:0]   ram_addr_write;
    logic [399:0] ram_din;
    logic         ram_ena_r;
    logic [9:0]   ram_addr_read;
    logic [15:0]  ram_dout;
    logic [15:0]  w_data;
    logic         w_valid;
    logic         w_ready;
    logic         w_last;
    logic         busy;
    logic         done;
    logic         err;
`ifdef WEIGHT_SCHED_PERF_EN
    logic [15:0]  perf_stall_cnt;
`endif

    weight_ram_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ks             (ks),
        .slice_num      (slice_num),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .ram_ena_w      (ram_ena_w),
        .ram_addr_write (ram_addr_write),
        .ram_din        (ram_din),
        .ram_ena_r      (ram_ena_r),
        .ram_addr_read  (ram_addr_read),
        .ram_dout       (ram_dout),
        .w_data         (w_data),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_last         (w_last),
        .busy           (busy),
        .done           (done),
        .err            (err)
`ifdef WEIGHT_SCHED_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wval(input int a);
        return 16'h1000 + 16'((a / 25) * 256 + (a % 25));
    endfunction

    function automatic int exp_addr(input int k, input int kk);
        int sq;
        sq = kk * kk;
        return (k / sq) * 25 + ((k % sq) / kk) * 5 + (k % kk);
    endfunction

    // Slice data is a function of the slot being written, so every word is traceable to its address.
    always_comb begin
        load_data = '0;
        for (int k = 0; k < 25; k++) begin
            load_data[16*k +: 16] = wval(int'(ram_addr_write) * 25 + k);
        end
    end

    logic [15:0] mem [0:99];
    logic        mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 100; i++) mem[i] <= 16'hDEAD;
            ram_dout <= 16'h0;
        end else begin
            if (ram_ena_w && ram_addr_write < 5'd4) begin
                for (int k = 0; k < 25; k++) mem[int'(ram_addr_write) * 25 + k] <= ram_din[16*k +: 16];
            end
            if (ram_ena_r) begin
                ram_dout <= (ram_addr_read < 10'd100) ? mem[ram_addr_read] : 16'hBAD0;
            end
        end
    end

    int rdy_mode;
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) w_ready = ~w_ready;
            else w_ready = 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        stat_clr;
    int          cur_ks;
    int          n_wr, n_bad_waddr, n_rd, n_bad_raddr, n_hs, n_bad_data, n_bad_last, n_last;
    int          n_done, n_err, n_err_nodone, n_overlap, n_unstable, n_stall, hs_cyc, done_cyc;
    logic        prev_stall;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        if (stat_clr) begin
            n_wr = 0; n_bad_waddr = 0; n_rd = 0; n_bad_raddr = 0; n_hs = 0; n_bad_data = 0;
            n_bad_last = 0; n_last = 0; n_done = 0; n_err = 0; n_err_nodone = 0; n_overlap = 0;
            n_unstable = 0; n_stall = 0; hs_cyc = 0; done_cyc = 0; prev_stall = 1'b0; prev_data = 16'h0;
        end else begin
            if (ram_ena_w) begin
                if (int'(ram_addr_write) != n_wr) n_bad_waddr++;
                n_wr++;
            end
            if (ram_ena_r) begin
                if (int'(ram_addr_read) != exp_addr(n_rd, cur_ks)) n_bad_raddr++;
                n_rd++;
            end
            if (ram_ena_w && ram_ena_r) n_overlap++;
            if (w_valid && prev_stall && w_data != prev_data) n_unstable++;
            if (w_valid && !w_ready) n_stall++;
            if (w_valid && w_ready) begin
                if (w_data != wval(exp_addr(n_hs, cur_ks))) n_bad_data++;
                if (w_last != ((n_hs % (cur_ks * cur_ks)) == cur_ks * cur_ks - 1)) n_bad_last++;
                if (w_last) n_last++;
                n_hs++;
                hs_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (err) n_err++;
            if (err && !done) n_err_nodone++;
            prev_stall = w_valid && !w_ready;
            prev_data  = w_data;
        end
    end

    task automatic clr_stats();
        @(posedge clk);
        #1;
        stat_clr = 1'b1;
        @(negedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [2:0] k, input logic [2:0] n);
        @(posedge clk);
        #1;
        ks = k;
        slice_num = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string t, input int budget);
        int c;
        c = 0;
        while (n_done == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({t, ".timeout"}, 32'(n_done != 0), 32'd1);
        repeat (2) @(negedge clk);
        chk({t, ".idle_after"}, {30'd0, busy, w_valid}, 32'd0);
    endtask

    task automatic wait_hs(input string t, input int target, input int budget);
        int c;
        c = 0;
        while (n_hs < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({t, ".hs_reached"}, 32'(n_hs >= target), 32'd1);
    endtask

    task automatic check_job(input string t, input int wr, input int hs, input int lasts, input int errs);
        chk({t, ".writes"}, n_wr, wr);
        chk({t, ".waddr"}, n_bad_waddr, 0);
        chk({t, ".reads"}, n_rd, hs);
        chk({t, ".raddr"}, n_bad_raddr, 0);
        chk({t, ".handshakes"}, n_hs, hs);
        chk({t, ".wdata"}, n_bad_data, 0);
        chk({t, ".wlast_pos"}, n_bad_last, 0);
        chk({t, ".wlast_cnt"}, n_last, lasts);
        chk({t, ".done_cnt"}, n_done, 1);
        chk({t, ".err_cnt"}, n_err, errs);
        chk({t, ".err_wo_done"}, n_err_nodone, 0);
        chk({t, ".rw_overlap"}, n_overlap, 0);
        chk({t, ".stall_stable"}, n_unstable, 0);
        if (hs > 0) chk({t, ".done_gap"}, done_cyc - hs_cyc, 1);
    endtask

    int ill_ks [3] = '{0, 6, 3};
    int ill_n  [3] = '{2, 2, 5};

    initial begin
        rst = 1'b1; start = 1'b0; ks = 3'd0; slice_num = 3'd0; load_valid = 1'b0;
        rdy_mode = 0; stat_clr = 1'b1; mem_clr = 1'b1; cur_ks = 1;
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk("reset.outs", {24'd0, busy, w_valid, w_last, load_ready, ram_ena_w, ram_ena_r, done, err}, 32'd0);
        chk("reset.raddr", 32'(ram_addr_read), 32'd0);
        rst = 1'b0;
        stat_clr = 1'b0;

        clr_stats();
        cur_ks = 3; load_valid = 1'b1; rdy_mode = 0;
        pulse_start(3'd3, 3'd2);
        wait_done("t1", 200);
        check_job("t1", 2, 18, 2, 0);

        clr_stats();
        cur_ks = 5; rdy_mode = 1;
        pulse_start(3'd5, 3'd4);
        wait_done("t2", 1000);
        check_job("t2", 4, 100, 4, 0);
        chk("t2.stalls_seen", 32'(n_stall > 0), 32'd1);
`ifdef WEIGHT_SCHED_PERF_EN
        chk("t2.perf_stall", 32'(perf_stall_cnt), n_stall);
`endif
        rdy_mode = 0;

        for (int i = 0; i < 3; i++) begin
            clr_stats();
            cur_ks = 1;
            pulse_start(3'(ill_ks[i]), 3'(ill_n[i]));
            wait_done($sformatf("t3_%0d", i), 50);
            check_job($sformatf("t3_%0d", i), 0, 0, 0, 1);
        end

        clr_stats();
        cur_ks = 2; load_valid = 1'b0;
        pulse_start(3'd2, 3'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("t4.load_ready", 32'(load_ready), 32'd1);
        chk("t4.no_writes", n_wr, 0);
        chk("t4.no_reads", n_rd, 0);
        chk("t4.busy", 32'(busy), 32'd1);
        load_valid = 1'b1;
        wait_done("t4", 100);
        check_job("t4", 1, 4, 1, 0);

        clr_stats();
        cur_ks = 4;
        pulse_start(3'd4, 3'd2);
        wait_hs("t5", 7, 200);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5.rst_outs", {28'd0, busy, w_valid, ram_ena_r, ram_ena_w}, 32'd0);
        rst = 1'b0;
        clr_stats();
        cur_ks = 1;
        pulse_start(3'd1, 3'd1);
        wait_done("t5b", 100);
        check_job("t5b", 1, 1, 1, 0);

        clr_stats();
        cur_ks = 2;
        pulse_start(3'd2, 3'd2);
        wait_hs("t6", 2, 200);
        pulse_start(3'd1, 3'd1);
        wait_done("t6", 200);
        check_job("t6", 2, 8, 2, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
